fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_normalizer.sv | 145 ++++++++++++++
 tb/tb_fp_normalizer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative post-arithmetic normalizer for a single-precision datapath.
// A raw 29-bit significand (carry, hidden bit, fraction, 4-bit extension) and its
// biased exponent are shifted one position per cycle until the hidden bit is set.
// The result is then presented in rounder format, with the hidden bit stripped.
// Optional feature macro: FP_NORMALIZER_SUBNORMAL_EN. When it is defined, subnormal
// results keep their fraction (gradual underflow); otherwise they flush to zero.
module fp_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  exponentIn,
  input  logic [28:0] mantissaIn,
  output logic        busy,
  output logic        done,
  output logic [7:0]  exponentOut,
  output logic [26:0] mantissaOut,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  logic [28:0] mReg;
  logic [7:0]  eReg;
  logic        zeroReg;
  logic        ovfReg;

  // Right shift by one. The bit shifted out is ORed into the new LSB so that
  // the sticky information survives for the rounder.
  function automatic logic [28:0] shiftRightSticky(input logic [28:0] m);
    return {1'b0, m[28:2], m[1] | m[0]};
  endfunction

  // Left shift by one with a zero fill.
  function automatic logic [28:0] shiftLeftZero(input logic [28:0] m);
    return {m[27:0], 1'b0};
  endfunction

  // Biased exponent 0 denotes the same scale as exponent 1.
  function automatic logic [7:0] mapExponent(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mReg        <= 29'd0;
      eReg        <= 8'd0;
      zeroReg     <= 1'b0;
      ovfReg      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      exponentOut <= 8'd0;
      mantissaOut <= 27'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // While done is high the FSM is already back in IDLE, but a start in
          // that cycle is ignored, so only a start after the done cycle counts.
          if (start && !done) begin
            mReg    <= mantissaIn;
            eReg    <= mapExponent(exponentIn);
            zeroReg <= 1'b0;
            ovfReg  <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          if (mReg == 29'd0) begin
            zeroReg <= 1'b1;
            state   <= FINISH;
          end else if (mReg[28]) begin
            mReg <= shiftRightSticky(mReg);
            // An incremented exponent of 255 or more cannot be represented,
            // so normalization stops and the result becomes an overflow.
            if (eReg >= 8'd254) begin
              eReg   <= 8'd255;
              ovfReg <= 1'b1;
              state  <= FINISH;
            end else begin
              eReg  <= eReg + 8'd1;
              state <= SHIFT;
            end
          end else if (!mReg[27] && (eReg > 8'd1)) begin
            mReg  <= shiftLeftZero(mReg);
            eReg  <= eReg - 8'd1;
            state <= SHIFT;
          end else begin
            state <= FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (zeroReg) begin
            exponentOut <= 8'd0;
            mantissaOut <= 27'd0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
          end else if (ovfReg) begin
            exponentOut <= 8'd255;
            mantissaOut <= 27'd0;
            overflow    <= 1'b1;
            underflow   <= 1'b0;
          end else if ((eReg == 8'd1) && !mReg[27]) begin
            exponentOut <= 8'd0;
`ifdef FP_NORMALIZER_SUBNORMAL_EN
            mantissaOut <= mReg[26:0];
`else
            mantissaOut <= 27'd0;
`endif
            overflow    <= 1'b0;
            underflow   <= 1'b1;
          end else begin
            exponentOut <= eReg;
            mantissaOut <= mReg[26:0];
            overflow    <= 1'b0;
            underflow   <= 1'b0;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Testbench for fp_normalizer: directed table vectors, hand-written multi-cycle
// sequences (busy start, done-cycle start, mid-run reset, hold) and randomized
// runs checked against a leading-one based reference model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  exponentIn;
  logic [28:0] mantissaIn;
  logic        busy;
  logic        done;
  logic [7:0]  exponentOut;
  logic [26:0] mantissaOut;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fp_normalizer dut (
    .clk(clk), .reset(reset), .start(start),
    .exponentIn(exponentIn), .mantissaIn(mantissaIn),
    .busy(busy), .done(done),
    .exponentOut(exponentOut), .mantissaOut(mantissaOut),
    .overflow(overflow), .underflow(underflow)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [26:0] m;
    logic        ovf;
    logic        unf;
    int          lat;
  } res_t;

  typedef struct {
    logic [7:0]  ei;
    logic [28:0] mi;
    res_t        exp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: locate the leading one and compute the whole result at once.
  function automatic res_t model(input logic [7:0] ei, input logic [28:0] mi);
    res_t r;
    int e;
    int p;
    int sh;
    logic [28:0] m;
    e = (ei == 8'd0) ? 1 : int'(ei);
    m = mi;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (m == 29'd0) begin
      r.e = 8'd0; r.m = 27'd0; r.lat = 2;
    end else if (m[28]) begin
      e = e + 1;
      if (e >= 255) begin
        r.e = 8'hFF; r.m = 27'd0; r.ovf = 1'b1; r.lat = 2;
      end else begin
        m = (m >> 1) | (m & 29'd1);
        r.e = 8'(e); r.m = m[26:0]; r.lat = 3;
      end
    end else begin
      p = 27;
      while (!m[p]) p--;
      sh = 27 - p;
      if (sh > e - 1) sh = e - 1;
      m = m << sh;
      e = e - sh;
      r.lat = 2 + sh;
      if (m[27]) begin
        r.e = 8'(e); r.m = m[26:0];
      end else begin
        r.e = 8'd0; r.unf = 1'b1;
`ifdef FP_NORMALIZER_SUBNORMAL_EN
        r.m = m[26:0];
`else
        r.m = 27'd0;
`endif
      end
    end
    return r;
  endfunction

  // Pulse start for one capture edge, then count edges until done (bounded).
  task automatic launch(input logic [7:0] ei, input logic [28:0] mi, output int lat);
    exponentIn = ei;
    mantissaIn = mi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runCheck(input string name, input logic [7:0] ei, input logic [28:0] mi,
                          input res_t ex);
    int lat;
    launch(ei, mi, lat);
    chk({name, " latency"}, lat, ex.lat);
    chk({name, " done"}, done, 1);
    chk({name, " busy"}, busy, 0);
    chk({name, " exponentOut"}, exponentOut, ex.e);
    chk({name, " mantissaOut"}, mantissaOut, ex.m);
    chk({name, " overflow"}, overflow, ex.ovf);
    chk({name, " underflow"}, underflow, ex.unf);
    @(posedge clk); #1;
    chk({name, " done one cycle"}, done, 0);
  endtask

  function automatic res_t mk(input logic [7:0] e, input logic [26:0] m,
                              input logic ovf, input logic unf, input int lat);
    res_t r;
    r.e = e; r.m = m; r.ovf = ovf; r.unf = unf; r.lat = lat;
    return r;
  endfunction

  vec_t vecs[8];

  initial begin
    int lat;
    int n;
    logic [28:0] rm;
    logic [7:0]  re;

    reset = 1'b1;
    start = 1'b0;
    exponentIn = 8'd0;
    mantissaIn = 29'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset exponentOut", exponentOut, 0);
    chk("reset mantissaOut", mantissaOut, 0);
    chk("reset flags", {overflow, underflow}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, expected values derived by hand.
    vecs[0] = '{8'h80, 29'h0800_0008, mk(8'h80, 27'h000_0008, 1'b0, 1'b0, 2)};
    vecs[1] = '{8'h80, 29'h1000_0003, mk(8'h81, 27'h000_0001, 1'b0, 1'b0, 3)};
    vecs[2] = '{8'h80, 29'h0000_0010, mk(8'h69, 27'h000_0000, 1'b0, 1'b0, 25)};
    vecs[3] = '{8'hFE, 29'h1000_0000, mk(8'hFF, 27'h000_0000, 1'b1, 1'b0, 2)};
`ifdef FP_NORMALIZER_SUBNORMAL_EN
    vecs[4] = '{8'h02, 29'h0040_0000, mk(8'h00, 27'h080_0000, 1'b0, 1'b1, 3)};
`else
    vecs[4] = '{8'h02, 29'h0040_0000, mk(8'h00, 27'h000_0000, 1'b0, 1'b1, 3)};
`endif
    vecs[5] = '{8'h80, 29'h0000_0000, mk(8'h00, 27'h000_0000, 1'b0, 1'b0, 2)};
    vecs[6] = '{8'h00, 29'h0FFF_FFFF, mk(8'h01, 27'h7FF_FFFF, 1'b0, 1'b0, 2)};
    vecs[7] = '{8'h80, 29'h0000_0001, mk(8'h65, 27'h000_0000, 1'b0, 1'b0, 29)};
    for (int i = 0; i < 8; i++) begin
      runCheck($sformatf("vec%0d", i), vecs[i].ei, vecs[i].mi, vecs[i].exp);
    end

    // Outputs hold after done; a start during busy does not disturb the run.
    repeat (3) @(posedge clk);
    #1;
    chk("hold exponentOut", exponentOut, 8'h65);
    exponentIn = 8'h80;
    mantissaIn = 29'h0000_0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy after start", busy, 1);
    chk("held while busy", exponentOut, 8'h65);
    repeat (3) @(posedge clk);
    #1;
    exponentIn = 8'h10;
    mantissaIn = 29'h1000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy-start latency", n, 25);
    chk("busy-start exponentOut", exponentOut, 8'h69);
    chk("busy-start mantissaOut", mantissaOut, 0);

    // Start in the done cycle is ignored.
    exponentIn = 8'h80;
    mantissaIn = 29'h0800_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done-cycle start busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("done-cycle start no result", exponentOut, 8'h69);

    // Reset in the middle of a long normalization.
    exponentIn = 8'h80;
    mantissaIn = 29'h0000_0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset outputs", {done, exponentOut, mantissaOut, overflow, underflow}, 0);
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      n += int'(done);
    end
    chk("midreset no done", n, 0);
    runCheck("after reset", 8'h80, 29'h0800_0008, mk(8'h80, 27'h000_0008, 1'b0, 1'b0, 2));

    // Reset has priority over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("reset over start busy", busy, 0);
    @(posedge clk); #1;
    chk("reset over start idle", busy, 0);

    // Randomized runs against the reference model.
    for (int i = 0; i < 300; i++) begin
      re = 8'($urandom_range(0, 254));
      case ($urandom_range(0, 3))
        0: rm = 29'($urandom) >> $urandom_range(0, 28);
        1: rm = 29'($urandom) | 29'h1000_0000;
        2: rm = (i % 7 == 0) ? 29'd0 : (29'd1 << $urandom_range(0, 28));
        default: rm = 29'($urandom);
      endcase
      if (i % 11 == 0) re = 8'($urandom_range(0, 4));
      if (i % 13 == 0) re = 8'($urandom_range(250, 254));
      runCheck($sformatf("rand%0d", i), re, rm, model(re, rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
